// File: rtl/rom_arbiter_pkg.sv
// Shared audio constants for the song ROM and its clients, plus small
// arbitration helpers reused by the ROM arbiter and later mixers.
package rom_arbiter_pkg;

    localparam int ROM_ADDR_WIDTH   = 8;
    localparam int ROM_DATA_WIDTH   = 16;
    localparam int ROM_READ_LATENCY = 1;
    localparam int NUM_VOICES       = 4;

    // Stage index of the output register: issue (0), ROM wait stage(s), output.
    localparam int PIPE_LAST = ROM_READ_LATENCY + 1;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// Client/ROM bus of the ROM arbiter: per-port requests and returns on one
// side, the shared synchronous ROM on the other.
interface rom_arbiter_if
    import rom_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = NUM_VOICES,
    parameter int ADDR_WIDTH = ROM_ADDR_WIDTH,
    parameter int DATA_WIDTH = ROM_DATA_WIDTH
);
    logic [NUM_PORTS-1:0]            i_req;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] i_addr;
    logic [NUM_PORTS-1:0]            o_gnt;
    logic [NUM_PORTS-1:0]            o_valid;
    logic [DATA_WIDTH-1:0]           o_data;
    logic [ADDR_WIDTH-1:0]           o_rom_addr;
    logic [DATA_WIDTH-1:0]           i_rom_data;

    modport slave (
        input  i_req, i_addr, i_rom_data,
        output o_gnt, o_valid, o_data, o_rom_addr
    );

    modport master (
        output i_req, i_addr, i_rom_data,
        input  o_gnt, o_valid, o_data, o_rom_addr
    );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first eligible requester at or after
// rr_ptr, wrapping, returned as one-hot, index and an any flag.
module rr_priority_picker #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     eligible,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N-1:0]     winner,
    output logic [PTR_W-1:0] winner_idx,
    output logic             any
);

    always_comb begin
        int k;
        k          = 0;
        winner     = '0;
        winner_idx = '0;
        any        = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = int'(rr_ptr) + i;
            if (k >= N) k = k - N;
            if (!any && eligible[k]) begin
                any        = 1'b1;
                winner[k]  = 1'b1;
                winner_idx = PTR_W'(k);
            end
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one synchronous song ROM among NUM_PORTS clients,
// one read issued per cycle and each word returned with a tagged valid pulse.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = NUM_VOICES,
    parameter int ADDR_WIDTH = ROM_ADDR_WIDTH,
    parameter int DATA_WIDTH = ROM_DATA_WIDTH
) (
    input  logic        i_clk,
    input  logic        i_rst,
    rom_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]                pending;
    logic [NUM_PORTS-1:0]                eligible;
    logic [NUM_PORTS-1:0]                win_oh;
    logic [PTR_W-1:0]                    win_idx;
    logic                                win_any;
    logic [PTR_W-1:0]                    rr_ptr;
    logic [PIPE_LAST:0]                  vld_pipe;
    logic [PIPE_LAST:0][NUM_PORTS-1:0]   tag_pipe;
    logic [ADDR_WIDTH-1:0]               rom_addr;
    logic [DATA_WIDTH-1:0]               data;
    logic [NUM_PORTS-1:0]                valid_now;

    // A port stays ineligible through its own valid cycle, so a request held
    // one cycle late by a registered client cannot cause a duplicate read.
    assign eligible  = bus.i_req & ~pending;
    assign valid_now = vld_pipe[PIPE_LAST] ? tag_pipe[PIPE_LAST] : '0;

    rr_priority_picker #(
        .N     (NUM_PORTS),
        .PTR_W (PTR_W)
    ) u_picker (
        .eligible   (eligible),
        .rr_ptr     (rr_ptr),
        .winner     (win_oh),
        .winner_idx (win_idx),
        .any        (win_any)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
            rom_addr <= '0;
            data     <= '0;
            pending  <= '0;
            rr_ptr   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[PIPE_LAST-1:0], win_any};
            tag_pipe <= {tag_pipe[PIPE_LAST-1:0], win_oh};
            rom_addr <= win_any ? bus.i_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
            if (vld_pipe[PIPE_LAST-1]) data <= bus.i_rom_data;
            pending  <= (pending | win_oh) & ~valid_now;
            if (win_any) rr_ptr <= PTR_W'(wrap_inc(int'(win_idx), NUM_PORTS));
        end
    end

    assign bus.o_gnt      = vld_pipe[0] ? tag_pipe[0] : '0;
    assign bus.o_valid    = valid_now;
    assign bus.o_data     = data;
    assign bus.o_rom_addr = rom_addr;

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Round-robin arbiter that shares the single synchronous song ROM (8-bit address, 16-bit word) among several ROM clients: per-channel pattern sequencers plus any order/instrument table readers. It sits between the clients and the ROM. It accepts one read request per cycle, pipelines the fixed ROM latency, and returns each word to the port that requested it with a one-cycle valid pulse. This lets multiple voices fetch notes from one ROM without a ROM copy per channel.

## Interface
- NUM_PORTS, 4: number of requesting clients; legal range 2–8.
- ADDR_WIDTH, 8: ROM address width.
- DATA_WIDTH, 16: ROM word width.
- i_clk  in  1  system clock. This is the block's only clock.
- i_rst  in  1  reset. Synchronous and active-high.
- i_req  in  NUM_PORTS  per-port read request. Level signal.
- i_addr  in  NUM_PORTS*ADDR_WIDTH  per-port address. Port p occupies bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- o_gnt  out  NUM_PORTS  one-hot grant. High in the cycle the port's address is on o_rom_addr.
- o_valid  out  NUM_PORTS  one-hot read-data-valid pulse.
- o_data  out  DATA_WIDTH  returned ROM word. Shared by all ports; qualified by o_valid.
- o_rom_addr  out  ADDR_WIDTH  ROM address.
- i_rom_data  in  DATA_WIDTH  ROM read data. Valid exactly one cycle after the matching o_rom_addr.

## Operation
- Client protocol:
  - A client raises i_req[p] and holds i_addr[p] stable until it sees o_valid[p].
  - After o_valid[p], the client drops i_req[p] or presents a new request.
  - A port has at most one read outstanding.
- pending[p] flag per port:
  - Set at the edge that grants p.
  - Cleared at the edge ending p's o_valid cycle.
- Eligible ports = i_req & ~pending.
  - The block ignores a request that is still high during its own o_valid cycle. This prevents a duplicate grant when a registered client drops i_req one cycle late.
- Arbitration at each edge:
  - If any port is eligible, the first eligible port at or after rr_ptr (wrapping modulo NUM_PORTS) wins.
  - The winner's address is registered into the issue stage, and rr_ptr becomes winner+1, wrapping NUM_PORTS-1 to 0.
  - With no eligible port, the issue stage is empty and rr_ptr holds.
- Three-stage pipeline, each stage holding a valid bit and a one-hot port tag:
  - Issue stage: drives o_rom_addr and o_gnt.
  - Wait stage: the ROM is producing i_rom_data.
  - Output stage: registered i_rom_data drives o_data, and the tag drives o_valid.
- Sustained throughput is one read per cycle across all ports. Each individual port is limited by its own round trip.
- When the issue stage is empty, o_rom_addr = 0 and o_gnt = 0.
- o_data holds its last value when o_valid = 0.
- Reset, including mid-operation:
  - Clears all pipeline valid bits, pending, rr_ptr, o_data and o_rom_addr to 0.
  - Reads in flight are discarded and produce no o_valid.
  - Clients must re-request after reset.

## Timing
- Request-to-data latency (no contention):
  - i_req[p] is first high in cycle t.
  - Cycle t+1: o_gnt[p] = 1 and o_rom_addr = i_addr[p].
  - Cycle t+2: i_rom_data carries the word.
  - Cycle t+3: o_valid[p] = 1 and o_data = the word.
- Under contention, a port waits at most NUM_PORTS-1 grant slots.
- The earliest re-grant of port p is the cycle after its o_valid cycle +1. If i_req[p] is still high at the edge ending the o_valid cycle, the block treats that as a new request next cycle only if it is still high then.
- Only one port can be granted per cycle, so o_gnt and o_valid are always one-hot or zero.
- Reset values: o_gnt = 0, o_valid = 0, o_data = 0, o_rom_addr = 0.

## Structure
- The shared audio package holds:
  - ROM_ADDR_WIDTH = 8 and ROM_DATA_WIDTH = 16, which are also used by the pattern sequencer.
  - ROM_READ_LATENCY = 1.
  - NUM_VOICES, which sets the default for NUM_PORTS.
- Sub-module rr_priority_picker is combinational. It takes eligible and rr_ptr and returns a one-hot winner, its index, and an any flag. It is reused by later mixers.
- The pipeline, pending mask and pointer live in rom_arbiter.

## Test plan
- Single request, no contention:
  - Stimulus: port 2 requests address 0x10 in cycle 0; the ROM model returns 0x1234.
  - Cycle 1: o_gnt = 0100 and o_rom_addr = 0x10.
  - Cycle 3: o_valid = 0100 and o_data = 0x1234. No other o_valid pulses occur.
- All ports at once:
  - Stimulus: all 4 ports request from reset with addresses 0x00/0x11/0x22/0x33.
  - Grants go to ports 0, 1, 2, 3 in cycles 1–4.
  - o_valid pulses appear in cycles 3–6, each with the matching ROM word.
- Fairness:
  - Stimulus: ports 0 and 3 re-request immediately after each o_valid for 40 cycles.
  - Grants alternate 0, 3, 0, 3. No port is granted twice while the other is eligible.
- Late request drop:
  - Stimulus: the client holds i_req[1] one cycle past o_valid[1], then drops it.
  - Exactly one grant and one o_valid occur for that request. There is no second read.
- Reset mid-flight:
  - Stimulus: i_rst is asserted in the cycle after o_gnt[0].
  - No o_valid appears; all outputs are 0 the cycle after the reset edge.
  - After release, the next request is granted normally, with rr_ptr back at port 0.
- Idle:
  - Stimulus: no requests for 20 cycles.
  - o_rom_addr = 0 and o_gnt = 0 throughout; o_data is unchanged.
